// File: rtl/rq_arith_pkg.sv
// Shared Rq arithmetic definitions: op encoding, prefix-tree geometry, cell primitives.
package rq_arith_pkg;

    typedef enum logic {
        RQ_ADD = 1'b0,
        RQ_SUB = 1'b1
    } rq_op_e;

    localparam int unsigned SRC_W = 16;

    // One prefix-tree position: does a cell sit here, is it black, which bit feeds it.
    typedef struct packed {
        logic             active;
        logic             black;
        logic [SRC_W-1:0] src;
    } prefix_cell_t;

    // Ceiling log2, used to size the prefix tree.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Sklansky geometry: at level lvl, bit i combines with the top bit of the
    // neighbouring 2^lvl block below it; the cell is grey once the group reaches bit 0.
    function automatic prefix_cell_t prefix_cell(input int unsigned lvl, input int unsigned bit_i);
        prefix_cell_t c;
        c.active = 1'(((bit_i >> lvl) & 32'd1) != 32'd0);
        c.black  = c.active && ((bit_i >> (lvl + 1)) != 32'd0);
        c.src    = c.active ? SRC_W'(((bit_i >> lvl) << lvl) - 32'd1) : SRC_W'(bit_i);
        return c;
    endfunction

    // Half adder: {generate, propagate}.
    function automatic logic [1:0] ha(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

    // Grey cell: group generate only.
    function automatic logic grey_cell(input logic gi, input logic pi, input logic gj);
        return gi | (pi & gj);
    endfunction

    // Black cell: group {generate, propagate}.
    function automatic logic [1:0] black_cell(input logic gi, input logic pi,
                                              input logic gj, input logic pj);
        return {gi | (pi & gj), pi & pj};
    endfunction

endpackage

// File: rtl/rq_prefix_lane.sv
// Combinational slice of a Sklansky prefix tree covering levels [LO_LEVEL, HI_LEVEL).
module rq_prefix_lane
    import rq_arith_pkg::*;
#(
    parameter int unsigned NUM_BIT  = 13,
    parameter int unsigned LO_LEVEL = 0,
    parameter int unsigned HI_LEVEL = 2
) (
    input  logic [NUM_BIT-1:0] g_in,
    input  logic [NUM_BIT-1:0] p_in,
    output logic [NUM_BIT-1:0] g_out,
    output logic [NUM_BIT-1:0] p_out
);

    localparam int unsigned NLV = HI_LEVEL - LO_LEVEL;

    logic [NLV:0][NUM_BIT-1:0] g_lv;
    logic [NLV:0][NUM_BIT-1:0] p_lv;

    assign g_lv[0] = g_in;
    assign p_lv[0] = p_in;

    // One row of cells per level; bits without a cell pass straight through.
    for (genvar l = 0; l < NLV; l++) begin : g_level
        for (genvar i = 0; i < NUM_BIT; i++) begin : g_bit
            localparam prefix_cell_t CELL = prefix_cell(LO_LEVEL + l, i);
            localparam int unsigned  SRC  = 32'(CELL.src);
            if (CELL.active && CELL.black) begin : g_black
                assign {g_lv[l+1][i], p_lv[l+1][i]} =
                    black_cell(g_lv[l][i], p_lv[l][i], g_lv[l][SRC], p_lv[l][SRC]);
            end else if (CELL.active) begin : g_grey
                assign g_lv[l+1][i] = grey_cell(g_lv[l][i], p_lv[l][i], g_lv[l][SRC]);
                assign p_lv[l+1][i] = 1'b0;
            end else begin : g_pass
                assign g_lv[l+1][i] = g_lv[l][i];
                assign p_lv[l+1][i] = p_lv[l][i];
            end
        end
    end

    assign g_out = g_lv[NLV];
    assign p_out = p_lv[NLV];

endmodule

// File: rtl/rq_addsub_pipe.sv
// Two-stage, multi-lane mod 2^NUM_BIT adder/subtractor with valid/ready backpressure.
module rq_addsub_pipe
    import rq_arith_pkg::*;
#(
    parameter int unsigned NUM_BIT = 13,
    parameter int unsigned LANES   = 4,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned SPLIT   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_op,
    input  logic [LANES*NUM_BIT-1:0] in_x1,
    input  logic [LANES*NUM_BIT-1:0] in_x2,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*NUM_BIT-1:0] out_sum,
    output logic [LANES-1:0]         out_cout,
    output logic [TAG_W-1:0]         out_tag
);

    localparam int unsigned LEVELS = clog2(NUM_BIT);
    localparam int unsigned VEC_W  = LANES * NUM_BIT;

    logic [VEC_W-1:0] gs_c, ps_c, p0_c, sum_c;
    logic [LANES-1:0] cout_c;

    logic [VEC_W-1:0] s1_g, s1_p, s1_p0;
    logic             s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_valid;

    logic [VEC_W-1:0] s2_sum;
    logic [LANES-1:0] s2_cout;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_valid;

    logic s2_adv;
    logic in_fire;

    // Per-lane datapath: g/p front end, lower tree levels, then upper levels and sum XOR.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [NUM_BIT-1:0] a, b, gh, g0, p0, gs, ps, gf, unused_p, p0_s1;
        logic               cin;

        assign cin = (in_op == RQ_SUB);
        assign a   = in_x1[k*NUM_BIT +: NUM_BIT];
        assign b   = cin ? ~in_x2[k*NUM_BIT +: NUM_BIT] : in_x2[k*NUM_BIT +: NUM_BIT];

        for (genvar i = 0; i < NUM_BIT; i++) begin : g_ha
            assign {gh[i], p0[i]} = ha(a[i], b[i]);
        end
        assign g0 = gh | NUM_BIT'(p0[0] & cin);

        rq_prefix_lane #(.NUM_BIT(NUM_BIT), .LO_LEVEL(0), .HI_LEVEL(SPLIT)) u_lo (
            .g_in (g0),
            .p_in (p0),
            .g_out(gs),
            .p_out(ps)
        );

        assign gs_c[k*NUM_BIT +: NUM_BIT] = gs;
        assign ps_c[k*NUM_BIT +: NUM_BIT] = ps;
        assign p0_c[k*NUM_BIT +: NUM_BIT] = p0;

        rq_prefix_lane #(.NUM_BIT(NUM_BIT), .LO_LEVEL(SPLIT), .HI_LEVEL(LEVELS)) u_hi (
            .g_in (s1_g[k*NUM_BIT +: NUM_BIT]),
            .p_in (s1_p[k*NUM_BIT +: NUM_BIT]),
            .g_out(gf),
            .p_out(unused_p)
        );

        assign p0_s1 = s1_p0[k*NUM_BIT +: NUM_BIT];
        assign sum_c[k*NUM_BIT +: NUM_BIT] = p0_s1 ^ ((gf << 1) | NUM_BIT'(s1_op));
        assign cout_c[k] = gf[NUM_BIT-1];
    end

    // Handshake: S2 advances when it is empty or being drained; S1 accepts when it frees up.
    always_comb begin
        s2_adv   = s1_valid & (~s2_valid | out_ready);
        in_ready = ~s1_valid | s2_adv;
        in_fire  = in_valid & in_ready;
    end

    // Stage 1: partial prefix vectors, p0, op and tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_g     <= '0;
            s1_p     <= '0;
            s1_p0    <= '0;
            s1_op    <= 1'b0;
            s1_tag   <= '0;
            s1_valid <= 1'b0;
        end else if (in_fire) begin
            s1_g     <= gs_c;
            s1_p     <= ps_c;
            s1_p0    <= p0_c;
            s1_op    <= in_op;
            s1_tag   <= in_tag;
            s1_valid <= 1'b1;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: finished result, held stable until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum   <= '0;
            s2_cout  <= '0;
            s2_tag   <= '0;
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_sum   <= sum_c;
            s2_cout  <= cout_c;
            s2_tag   <= s1_tag;
            s2_valid <= 1'b1;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;
    assign out_sum   = s2_sum;
    assign out_cout  = s2_cout;
    assign out_tag   = s2_tag;

endmodule

// File: tb/tb_rq_addsub_pipe.sv
// Self-checking bench for rq_addsub_pipe: directed cases plus randomized scoreboard run.
module tb_rq_addsub_pipe;

    localparam int unsigned NB = 13;
    localparam int unsigned LN = 4;
    localparam int unsigned TW = 8;
    localparam int unsigned SP = 2;
    localparam int unsigned VW = NB * LN;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_op;
    logic [VW-1:0] in_x1;
    logic [VW-1:0] in_x2;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [VW-1:0] out_sum;
    logic [LN-1:0] out_cout;
    logic [TW-1:0] out_tag;

    typedef struct packed {
        logic [VW-1:0] sum;
        logic [LN-1:0] cout;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    rq_addsub_pipe #(.NUM_BIT(NB), .LANES(LN), .TAG_W(TW), .SPLIT(SP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_x1    (in_x1),
        .in_x2    (in_x2),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_cout (out_cout),
        .out_tag  (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain modular arithmetic per lane; SUB carry means no borrow.
    function automatic exp_t model(input logic op, input logic [VW-1:0] a,
                                   input logic [VW-1:0] b, input logic [TW-1:0] tg);
        exp_t        r;
        int unsigned xa, xb, s, m;
        m = 1 << NB;
        for (int k = 0; k < LN; k++) begin
            xa = 32'(a[k*NB +: NB]);
            xb = 32'(b[k*NB +: NB]);
            if (!op) begin
                s = xa + xb;
                r.cout[k] = (s >= m);
            end else begin
                s = xa + m - xb;
                r.cout[k] = (xa >= xb);
            end
            r.sum[k*NB +: NB] = NB'(s % m);
        end
        r.tag = tg;
        return r;
    endfunction

    function automatic logic [VW-1:0] pack4(input int v0, input int v1, input int v2, input int v3);
        logic [VW-1:0] r;
        r = {NB'(v3), NB'(v2), NB'(v1), NB'(v0)};
        return r;
    endfunction

    // One clock: drive inputs in the low phase, score outputs, then advance to the next low phase.
    task automatic cycle(input logic iv, input logic op, input logic [VW-1:0] a,
                         input logic [VW-1:0] b, input logic [TW-1:0] tg,
                         input logic ordy, output logic fired, output logic rdy);
        in_valid  = iv;
        in_op     = op;
        in_x1     = a;
        in_x2     = b;
        in_tag    = tg;
        out_ready = ordy;
        #1;
        rdy   = in_ready;
        fired = iv & in_ready;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                check("sum", 64'(out_sum), 64'(sb[0].sum));
                check("cout", 64'(out_cout), 64'(sb[0].cout));
                check("tag", 64'(out_tag), 64'(sb[0].tag));
                if (ordy) void'(sb.pop_front());
            end
        end
        if (fired) sb.push_back(model(op, a, b, tg));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        logic f, r;
        cycle(1'b0, 1'b0, '0, '0, '0, ordy, f, r);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1'b1);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic          f, r;
        logic          op;
        int            t;
        logic [VW-1:0] a, b;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 1'b0;
        in_x1     = '0;
        in_x2     = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed ADD with latency check.
        cycle(1'b1, 1'b0, pack4(8191, 4096, 0, 1234), pack4(1, 4096, 0, 5678), 8'h11, 1'b1, f, r);
        check("add_accept", 64'(f), 64'd1);
        check("lat1_valid", 64'(out_valid), 64'd0);
        idle(1'b1);
        check("lat2_valid", 64'(out_valid), 64'd1);
        check("add_sum", 64'(out_sum), 64'(pack4(0, 0, 0, 6912)));
        check("add_cout", 64'(out_cout), 64'(4'b0011));
        idle(1'b1);

        // Directed SUB corners.
        cycle(1'b1, 1'b1, pack4(5, 7, 0, 0), pack4(7, 5, 0, 8191), 8'h22, 1'b1, f, r);
        idle(1'b1);
        check("sub_sum", 64'(out_sum), 64'(pack4(8190, 2, 0, 1)));
        check("sub_cout", 64'(out_cout), 64'(4'b0110));
        drain();

        // Backpressure: tags 1..5, consumer stalled for the first 6 cycles.
        t = 1;
        for (int c = 0; c < 30; c++) begin
            a = pack4(t * 100, t, 8191 - t, t * 7);
            b = pack4(t, t * 3, 5, 8000);
            cycle(t <= 5, 1'(t & 1), a, b, TW'(t), c >= 6, f, r);
            if (c < 2) check("bp_accept", 64'(f), 64'd1);
            if (c >= 2 && c < 6) check("bp_full_ready", 64'(r), 64'd0);
            if (f) t++;
        end
        check("bp_all_sent", 64'(t), 64'd6);
        drain();

        // Simultaneous accept and drain with both stages full.
        cycle(1'b1, 1'b0, pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 8'h31, 1'b0, f, r);
        cycle(1'b1, 1'b1, pack4(100, 2, 3, 4), pack4(10, 20, 30, 40), 8'h32, 1'b0, f, r);
        cycle(1'b1, 1'b0, pack4(7, 7, 7, 7), pack4(8, 8, 8, 8), 8'h33, 1'b1, f, r);
        check("sim_in_ready", 64'(r), 64'd1);
        check("sim_out_tag", 64'(out_tag), 64'h32);
        drain();

        // Reset with two transactions in flight.
        cycle(1'b1, 1'b0, pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 8'h41, 1'b0, f, r);
        cycle(1'b1, 1'b0, pack4(3, 3, 3, 3), pack4(4, 4, 4, 4), 8'h42, 1'b0, f, r);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_sum", 64'(out_sum), 64'd0);
        check("arst_out_cout", 64'(out_cout), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            check("no_ghost", 64'(out_valid), 64'd0);
        end

        // Randomized traffic, alternating ops, random consumer stalls.
        op = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            a = VW'({$urandom, $urandom});
            b = VW'({$urandom, $urandom});
            if ($urandom_range(0, 7) == 0) a = '1;
            if ($urandom_range(0, 7) == 0) b = '0;
            cycle($urandom_range(0, 3) != 0, op, a, b, TW'($urandom),
                  1'($urandom_range(0, 1)), f, r);
            if (f) op = ~op;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
